// File: rtl/mac_job_scheduler_if.sv
// Host-side job submission bundle for mac_job_scheduler.
// The master is the host/sequencer that pushes jobs; the slave is the scheduler's job FIFO.
interface mac_job_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              job_valid;
    logic              job_ready;
    logic [TAG_W-1:0]  job_tag;
    logic [ADDR_W-1:0] job_weight_base;
    logic [ADDR_W-1:0] job_result_base;
    logic              job_override;
    logic [DATA_W-1:0] job_in_dims;
    logic [DATA_W-1:0] job_wt_dims;

    modport master (
        output job_valid, job_tag, job_weight_base, job_result_base,
               job_override, job_in_dims, job_wt_dims,
        input  job_ready
    );

    modport slave (
        input  job_valid, job_tag, job_weight_base, job_result_base,
               job_override, job_in_dims, job_wt_dims,
        output job_ready
    );
endinterface

// File: rtl/mac_job_scheduler.sv
// Queues matrix-multiply jobs and issues them one at a time to the MAC datapath,
// tracking the MAC ready handshake for completion and guarding against a hung MAC.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a queued job; pops the FIFO head into mac_* regs
// ISSUE  | mac_valid high, waiting for the MAC to accept (mac_ready)
// BUSY   | MAC computing; watchdog running until the result-commit pulse
// FINISH | result committed, waiting for the MAC hold cycle (ready low)
// SETTLE | waiting for the MAC to return to idle; emits done_valid
module mac_job_scheduler #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                         clk,
    input  logic                         reset,
    mac_job_scheduler_if.slave           job,
    input  logic                         flush,
    output logic                         mac_valid,
    input  logic                         mac_ready,
    output logic [ADDR_W-1:0]            mac_weight_base,
    output logic [ADDR_W-1:0]            mac_result_base,
    output logic                         mac_override,
    output logic [DATA_W-1:0]            mac_in_dims,
    output logic [DATA_W-1:0]            mac_wt_dims,
    input  logic [DATA_W-1:0]            mac_in_rows,
    input  logic [DATA_W-1:0]            mac_in_cols,
    output logic                         done_valid,
    output logic [TAG_W-1:0]             done_tag,
    output logic [31:0]                  done_dims,
    output logic                         busy,
    output logic [$clog2(DEPTH):0]       queue_count,
    output logic [15:0]                  jobs_done,
    output logic                         timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int QC_W  = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_BUSY   = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] wbase;
        logic [ADDR_W-1:0] rbase;
        logic              ovr;
        logic [DATA_W-1:0] in_dims;
        logic [DATA_W-1:0] wt_dims;
    } job_t;

    job_t             mem [DEPTH];
    job_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [QC_W-1:0]  count;
    logic [2:0]       state;
    logic [WD_W-1:0]  wdog;
    logic [TAG_W-1:0] cur_tag;
    logic [31:0]      cap_dims;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    // Only the low halves of the MAC dimension outputs carry meaning.
    logic unused_dim_bits;
    assign unused_dim_bits = ^{mac_in_rows[DATA_W-1:16], mac_in_cols[DATA_W-1:16]};

    assign full          = (count == QC_W'(DEPTH));
    assign empty         = (count == '0);
    assign job.job_ready = !full;
    assign push          = job.job_valid && !full && !flush;
    assign pop           = (state == S_IDLE) && !empty && !flush;
    assign head          = mem[rd_ptr];

    assign queue_count = count;
    assign busy        = (state != S_IDLE);
    assign mac_valid   = (state == S_ISSUE);
    assign done_valid  = (state == S_SETTLE) && mac_ready;
    assign done_tag    = done_valid ? cur_tag : '0;
    assign done_dims   = done_valid ? cap_dims : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tag:     job.job_tag,
                             wbase:   job.job_weight_base,
                             rbase:   job.job_result_base,
                             ovr:     job.job_override,
                             in_dims: job.job_in_dims,
                             wt_dims: job.job_wt_dims};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + QC_W'(1);
                2'b01:   count <= count - QC_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            wdog            <= '0;
            cur_tag         <= '0;
            cap_dims        <= '0;
            mac_weight_base <= '0;
            mac_result_base <= '0;
            mac_override    <= 1'b0;
            mac_in_dims     <= '0;
            mac_wt_dims     <= '0;
            jobs_done       <= '0;
            timeout_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_tag         <= head.tag;
                        mac_weight_base <= head.wbase;
                        mac_result_base <= head.rbase;
                        mac_override    <= head.ovr;
                        mac_in_dims     <= head.in_dims;
                        mac_wt_dims     <= head.wt_dims;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mac_ready) begin
                        wdog  <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mac_ready) begin
                        cap_dims <= {mac_in_rows[15:0], mac_in_cols[15:0]};
                        state    <= S_FINISH;
                    end else if (wdog == WD_LAST) begin
                        // Abandon the hung job; its configuration is wiped so it cannot be mistaken for live.
                        timeout_err     <= 1'b1;
                        cur_tag         <= '0;
                        mac_weight_base <= '0;
                        mac_result_base <= '0;
                        mac_override    <= 1'b0;
                        mac_in_dims     <= '0;
                        mac_wt_dims     <= '0;
                        state           <= S_IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                S_FINISH: begin
                    if (!mac_ready) state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (mac_ready) begin
                        jobs_done <= jobs_done + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler: a small MAC handshake model plus a
// tag/dims scoreboard filled at push time and drained on each done_valid.
module tb_mac_job_scheduler;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 50;
    localparam int QC_W    = $clog2(DEPTH) + 1;
    localparam logic [31:0] DEF_DIMS = 32'h0005_0007;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              flush = 1'b0;
    logic              mac_ready = 1'b1;
    logic              mac_valid, mac_override, done_valid, busy, timeout_err;
    logic [ADDR_W-1:0] mac_weight_base, mac_result_base;
    logic [DATA_W-1:0] mac_in_dims, mac_wt_dims;
    logic [DATA_W-1:0] mac_in_rows = 32'hDEAD_0000;
    logic [DATA_W-1:0] mac_in_cols = 32'hBEEF_0000;
    logic [TAG_W-1:0]  done_tag;
    logic [31:0]       done_dims;
    logic [QC_W-1:0]   queue_count;
    logic [15:0]       jobs_done;

    mac_job_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) job_if ();

    mac_job_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .job(job_if), .flush(flush),
        .mac_valid(mac_valid), .mac_ready(mac_ready),
        .mac_weight_base(mac_weight_base), .mac_result_base(mac_result_base),
        .mac_override(mac_override), .mac_in_dims(mac_in_dims), .mac_wt_dims(mac_wt_dims),
        .mac_in_rows(mac_in_rows), .mac_in_cols(mac_in_cols),
        .done_valid(done_valid), .done_tag(done_tag), .done_dims(done_dims),
        .busy(busy), .queue_count(queue_count), .jobs_done(jobs_done), .timeout_err(timeout_err)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
        end
    endtask

    logic [35:0] sb[$];
    logic [35:0] sb_head;
    int  done_seen = 0;
    int  max_qc = 0;

    // Scoreboard drain, sampled mid-phase once the MAC model's ready update has settled.
    always @(negedge clk) begin
        #2;
        if (done_valid) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", done_valid, 1'b0);
            end else begin
                sb_head = sb.pop_front();
                check("done_tag", done_tag, sb_head[35:32]);
                check("done_dims", done_dims, sb_head[31:0]);
            end
        end
        if (int'(queue_count) > max_qc) max_qc = int'(queue_count);
    end

    // MAC model: accept while ready, compute for lat cycles, commit pulse, hold, idle.
    int lat = 2;
    bit hang = 1'b0;
    int mstate = 0;
    int mcnt = 0;
    int issues = 0;
    always @(negedge clk) begin
        if (reset || !busy) begin
            mstate    = 0;
            mac_ready = 1'b1;
        end else begin
            case (mstate)
                0: if (mac_valid) begin
                    issues++;
                    mstate = 1;
                    if (mac_override) begin
                        mac_in_rows = {16'hFFFF, mac_in_dims[31:16]};
                        mac_in_cols = {16'hEEEE, mac_in_dims[15:0]};
                    end else begin
                        mac_in_rows = 32'hABCD_0005;
                        mac_in_cols = 32'h1234_0007;
                    end
                end
                1: begin mac_ready = 1'b0; mcnt = lat; mstate = 2; end
                2: if (!hang) begin
                    if (mcnt == 0) begin mac_ready = 1'b1; mstate = 3; end
                    else mcnt--;
                end
                3: begin mac_ready = 1'b0; mstate = 4; end
                default: begin
                    mac_ready   = 1'b1;
                    mstate      = 0;
                    mac_in_rows = 32'hDEAD_0000;
                    mac_in_cols = 32'hBEEF_0000;
                end
            endcase
        end
    end

    task automatic push_job(input logic [TAG_W-1:0] tag, input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] rb,
                            input logic ov, input logic [31:0] ind, input logic [31:0] wtd, input bit expect_done);
        int n = 0;
        job_if.job_valid       = 1'b1;
        job_if.job_tag         = tag;
        job_if.job_weight_base = wb;
        job_if.job_result_base = rb;
        job_if.job_override    = ov;
        job_if.job_in_dims     = ind;
        job_if.job_wt_dims     = wtd;
        while (!job_if.job_ready && n < 400) begin @(negedge clk); n++; end
        if (!job_if.job_ready) check("push_stall_bound", job_if.job_ready, 1'b1);
        @(posedge clk);
        if (expect_done) sb.push_back({tag, ov ? ind : DEF_DIMS});
        @(negedge clk);
        job_if.job_valid = 1'b0;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!mac_valid && n < 400) begin @(negedge clk); n++; end
        if (!mac_valid) check("issue_bound", mac_valid, 1'b1);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < lim) begin @(negedge clk); n++; end
        if (sb.size() != 0 || busy) check("done_bound", sb.size(), 0);
    endtask

    int  exp_jobs = 0;
    int  n_busy;
    int  iss0;
    int  seen0;
    bit  stable;

    initial begin
        job_if.job_valid = 1'b0;
        job_if.job_tag = '0;
        job_if.job_weight_base = '0;
        job_if.job_result_base = '0;
        job_if.job_override = 1'b0;
        job_if.job_in_dims = '0;
        job_if.job_wt_dims = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_job_ready", job_if.job_ready, 1'b1);
        check("rst_mac_valid", mac_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_queue_count", queue_count, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_cfg", {mac_weight_base, mac_result_base, mac_override}, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Single job: mac_valid two cycles after the push handshake
        lat = 2;
        push_job(4'd3, 16'h0100, 16'h0200, 1'b0, 32'h0, 32'h0, 1'b1);
        exp_jobs++;
        check("t1_valid_next_cycle", mac_valid, 1'b0);
        @(negedge clk);
        check("t1_valid_second_cycle", mac_valid, 1'b1);
        check("t1_weight_base", mac_weight_base, 16'h0100);
        check("t1_result_base", mac_result_base, 16'h0200);
        check("t1_override", mac_override, 1'b0);
        wait_done(200);
        check("t1_done_count", done_seen, 1);
        check("t1_jobs_done", jobs_done, exp_jobs);

        // Back-to-back: blocker in flight, 4 fill the FIFO, 5th stalls until first pop
        lat = 30;
        push_job(4'd15, 16'h0010, 16'h0020, 1'b0, 32'h0, 32'h0, 1'b1);
        exp_jobs++;
        wait_issue();
        for (int t = 0; t < 4; t++) begin
            push_job(TAG_W'(t), 16'h1000 + 16'(t), 16'h2000 + 16'(t), 1'b0, 32'h0, 32'h0, 1'b1);
            exp_jobs++;
        end
        check("t2_ready_full", job_if.job_ready, 1'b0);
        check("t2_count_full", queue_count, 4);
        iss0 = issues;
        push_job(4'd4, 16'h1004, 16'h2004, 1'b0, 32'h0, 32'h0, 1'b1);
        exp_jobs++;
        check("t2_fifth_after_pop", issues, iss0 + 1);
        wait_done(1500);
        check("t2_max_queue", max_qc, 4);
        check("t2_jobs_done", jobs_done, exp_jobs);

        // Override job: config held stable throughout
        lat = 4;
        push_job(4'd7, 16'h0300, 16'h0400, 1'b1, 32'h0002_0003, 32'h0003_0004, 1'b1);
        exp_jobs++;
        wait_issue();
        stable = 1'b1;
        for (int n = 0; n < 200 && busy; n++) begin
            if (mac_override !== 1'b1 || mac_in_dims !== 32'h0002_0003 || mac_wt_dims !== 32'h0003_0004)
                stable = 1'b0;
            @(negedge clk);
        end
        check("t3_cfg_stable", stable, 1'b1);
        wait_done(200);
        check("t3_jobs_done", jobs_done, exp_jobs);

        // Watchdog: MAC never commits
        hang = 1'b1;
        seen0 = done_seen;
        push_job(4'd9, 16'h0900, 16'h0A00, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_issue();
        n_busy = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) break;
            n_busy++;
            if (n_busy == TIMEOUT) check("t4_err_before_limit", timeout_err, 1'b0);
        end
        check("t4_busy_cycles", n_busy, TIMEOUT);
        check("t4_timeout_err", timeout_err, 1'b1);
        check("t4_cfg_cleared", mac_weight_base, 16'h0);
        check("t4_no_done", done_seen, seen0);
        hang = 1'b0;
        lat = 1;
        push_job(4'd4, 16'h0500, 16'h0600, 1'b0, 32'h0, 32'h0, 1'b1);
        exp_jobs++;
        wait_done(200);
        check("t4_jobs_after_timeout", jobs_done, exp_jobs);
        check("t4_err_sticky", timeout_err, 1'b1);

        // Flush while job A in flight; simultaneous push is dropped
        lat = 20;
        push_job(4'd10, 16'h0A10, 16'h0A20, 1'b0, 32'h0, 32'h0, 1'b1);
        exp_jobs++;
        wait_issue();
        push_job(4'd11, 16'h0B00, 16'h0B01, 1'b0, 32'h0, 32'h0, 1'b0);
        push_job(4'd12, 16'h0C00, 16'h0C01, 1'b0, 32'h0, 32'h0, 1'b0);
        push_job(4'd13, 16'h0D00, 16'h0D01, 1'b0, 32'h0, 32'h0, 1'b0);
        check("t5_queued", queue_count, 3);
        flush = 1'b1;
        job_if.job_valid = 1'b1;
        job_if.job_tag = 4'd14;
        @(negedge clk);
        flush = 1'b0;
        job_if.job_valid = 1'b0;
        check("t5_flushed_count", queue_count, 0);
        iss0 = issues;
        wait_done(200);
        repeat (20) @(negedge clk);
        check("t5_no_reissue", issues, iss0);
        check("t5_idle", busy, 1'b0);
        check("t5_jobs_done", jobs_done, exp_jobs);

        // Reset during BUSY
        lat = 30;
        push_job(4'd1, 16'h0110, 16'h0120, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_issue();
        @(negedge clk);
        push_job(4'd2, 16'h0210, 16'h0220, 1'b0, 32'h0, 32'h0, 1'b0);
        check("t6_busy_before", busy, 1'b1);
        check("t6_queued_before", queue_count, 1);
        seen0 = done_seen;
        iss0 = issues;
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy", busy, 1'b0);
        check("t6_mac_valid", mac_valid, 1'b0);
        check("t6_job_ready", job_if.job_ready, 1'b1);
        check("t6_queue_count", queue_count, 0);
        check("t6_timeout_cleared", timeout_err, 1'b0);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("t6_no_done", done_seen, seen0);
        check("t6_no_issue", issues, iss0);
        check("t6_jobs_done", jobs_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
